mult_repeated_add: RTL and testbench

//   Unsigned multiplier that computes A*B by repeated addition: P += A, B -= 1 until B == 0.

---
 rtl/mra_pkg.sv | 22 ++
 rtl/mult_repeated_add_ctrl.sv | 80 ++++++++
 rtl/mult_repeated_add.sv | 82 ++++++++
 tb/tb_mult_repeated_add.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mra_pkg.sv
// ============================================================================
//  Module   : mra_pkg
//  Brief    : Shared types and constants for the repeated-add multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mra_pkg;

    localparam int MRA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_repeated_add_ctrl.sv
// ============================================================================
//  Module   : mra_ctrl
//  Brief    : Control FSM sequencing operand loads and the add/decrement loop.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mra_ctrl
    import mra_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic eq,
    output logic ld_a,
    output logic ld_b,
    output logic ld_p,
    output logic clr_p,
    output logic dec_b,
    output logic done
);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_p      = 1'b0;
        clr_p     = 1'b0;
        dec_b     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LDA;
                end
            end
            LDA: begin
                ld_a      = 1'b1;
                state_nxt = LDB;
            end
            LDB: begin
                ld_b      = 1'b1;
                clr_p     = 1'b1;
                state_nxt = ADD;
            end
            ADD: begin
                // Loop exit cycle performs no register update.
                if (eq) begin
                    state_nxt = DONE;
                end else begin
                    ld_p  = 1'b1;
                    dec_b = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mult_repeated_add.sv
// ============================================================================
//  Module   : mult_repeated_add
//  Brief    : Unsigned multiplier by repeated addition (P += A, B -= 1).
//             Define MRA_MIN_ITER_EN to load the smaller operand as the counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_repeated_add
    import mra_pkg::*;
#(
    parameter int WIDTH = MRA_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] p_reg;
    logic               eq;
    logic               ld_a;
    logic               ld_b;
    logic               ld_p;
    logic               clr_p;
    logic               dec_b;

    assign eq      = (b_reg == '0);
    assign product = p_reg;

    mra_ctrl u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .eq    (eq),
        .ld_a  (ld_a),
        .ld_b  (ld_b),
        .ld_p  (ld_p),
        .clr_p (clr_p),
        .dec_b (dec_b),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
        end else begin
            if (ld_a) begin
                a_reg <= data_in;
            end
            if (ld_b) begin
`ifdef MRA_MIN_ITER_EN
                // Keep the smaller operand in the loop counter.
                if (data_in > a_reg) begin
                    b_reg <= a_reg;
                    a_reg <= data_in;
                end else begin
                    b_reg <= data_in;
                end
`else
                b_reg <= data_in;
`endif
            end else if (dec_b) begin
                b_reg <= b_reg - WIDTH'(1);
            end
            if (clr_p) begin
                p_reg <= '0;
            end else if (ld_p) begin
                p_reg <= p_reg + {{WIDTH{1'b0}}, a_reg};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_repeated_add.sv
// ============================================================================
//  Module   : tb_mult_repeated_add
//  Brief    : Directed self-checking bench for mult_repeated_add.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_repeated_add;

    localparam int WIDTH = 16;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   data_in;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int n_cmp;
    int n_err;

    mult_repeated_add #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int exp_lat(input int a, input int b);
`ifdef MRA_MIN_ITER_EN
        return 3 + ((a < b) ? a : b);
`else
        return 3 + b;
`endif
    endfunction

    // Runs one operation; edge 0 samples start=1 in IDLE. Returns with done high
    // (or after a timeout) and start still at its held level.
    task automatic run_op(input string tag, input int a, input int b, input bit hold);
        int edge_n;
        edge_n = -1;
        @(negedge clk);
        start   = 1'b1;
        data_in = WIDTH'(a);
        @(posedge clk);
        edge_n = 0;
        @(negedge clk);
        if (!hold) start = 1'b0;
        @(posedge clk);
        edge_n = 1;
        @(negedge clk);
        data_in = WIDTH'(b);
        @(posedge clk);
        edge_n = 2;
        @(negedge clk);
        data_in = WIDTH'($urandom);
        while (!done && edge_n < 70000) begin
            @(posedge clk);
            edge_n++;
            #1;
        end
        chk({tag, "_latency"}, 32'(edge_n), 32'(exp_lat(a, b)));
        chk({tag, "_product"}, product, 32'(a) * 32'(b));
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_product", product, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("7x16", 7, 16, 1'b0);
        release_start();
        chk("idle_after_7x16", {31'b0, done}, 32'd0);
        run_op("9x0", 9, 0, 1'b0);
        release_start();
        run_op("0x5", 0, 5, 1'b0);
        release_start();
        run_op("ffffx3", 16'hFFFF, 3, 1'b0);
        release_start();
        run_op("2x100", 2, 100, 1'b0);
        release_start();

        // Reset in the middle of the add loop.
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data_in = 16'd16;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midadd_rst_done", {31'b0, done}, 32'd0);
        chk("midadd_rst_product", product, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("idle_after_rst", {31'b0, done}, 32'd0);

        // start held high through DONE keeps done asserted.
        run_op("3x2_hold", 3, 2, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_done", {31'b0, done}, 32'd1);
        chk("hold_product", product, 32'd6);
        release_start();
        chk("release_done", {31'b0, done}, 32'd0);
        run_op("5x4", 5, 4, 1'b0);
        release_start();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
